// File: rtl/fxd2float_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fxd2float_pkg
//  Purpose  : Shared helpers for the fixed-point to float converter:
//             exponent bias, width of a bit-position field and a field
//             splitter for packed {sign, exponent, mantissa} words.
//  Revision : 1.0 - initial release
// ============================================================================
package fxd2float_pkg;

    // Generic view of a packed float word, wide enough for any supported format.
    typedef struct packed {
        logic        sign;
        logic [31:0] exp;
        logic [63:0] man;
    } float_fields_t;

    // Exponent bias for an exponent field of exp_w bits.
    function automatic int BIAS(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Bits needed to hold a bit position 0..w-1 (at least one bit).
    function automatic int pos_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Split a right-aligned {sign, exp, man} word into its fields.
    function automatic float_fields_t float_fields(input logic [127:0] word,
                                                   input int exp_w,
                                                   input int man_w);
        float_fields_t f;
        f      = '0;
        f.sign = word[exp_w + man_w];
        for (int i = 0; i < exp_w && i < 32; i++) f.exp[i] = word[man_w + i];
        for (int i = 0; i < man_w && i < 64; i++) f.man[i] = word[i];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxd2float_pipe_lzc.sv
`default_nettype none
// ============================================================================
//  Module   : lzc
//  Purpose  : Combinational leading-zero counter.
//  Ports    : i_vec    - input vector
//             o_count  - number of zeros above the most significant 1
//             o_zero   - i_vec is all zeros (o_count is 0 then)
//  Revision : 1.0 - initial release
// ============================================================================
module lzc
    import fxd2float_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int CNT_W = pos_width(WIDTH)
)(
    input  logic [WIDTH-1:0] i_vec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    // Upward scan: the last hit is the most significant set bit.
    always_comb begin
        o_count = '0;
        o_zero  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
                o_zero  = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fxd2float_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fxd2float_pipe
//  Purpose  : Three-stage pipelined fixed-point (Qm.n, signed/unsigned) to
//             float converter, round-to-nearest-even, valid/ready handshake
//             with full back-pressure.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_valid/in_ready   - input handshake, in_data fixed-point sample
//             out_valid/out_ready - output handshake
//             out_data            - {sign, exponent, mantissa}
//             out_zero            - input was exactly zero
//             out_inexact         - rounding discarded nonzero bits
//  Revision : 1.0 - initial release
// ============================================================================
module fxd2float_pipe
    import fxd2float_pkg::*;
#(
    parameter int IN_W   = 19,
    parameter int FRAC_W = 0,
    parameter int SIGNED = 0,
    parameter int MAN    = 23,
    parameter int EXP    = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP+MAN:0]   out_data,
    output logic               out_zero,
    output logic               out_inexact
);

    localparam int c_bias     = BIAS(EXP);
    localparam int c_pw       = pos_width(IN_W);
    // Magnitude plus MAN+2 zero bits: room for hidden bit, mantissa and guard
    // even when the input is narrower than the mantissa.
    localparam int c_nw       = IN_W + MAN + 2;
    // exponent = bias + p - FRAC_W with p = IN_W-1-lz
    localparam int c_exp_base = c_bias + IN_W - 1 - FRAC_W;

    if ((IN_W - FRAC_W > c_bias) || (FRAC_W > c_bias - 1)) begin : g_range_check
        $error("fxd2float_pipe: input range does not fit the normal exponent range");
    end

    // ------------------------------------------------------------------------
    // Handshake: a stage loads when its successor is empty or advancing.
    // ------------------------------------------------------------------------
    logic w_ld1, w_ld2, w_ld3;
    logic r_s1_valid, r_s2_valid;

    assign w_ld3    = !out_valid  || out_ready;
    assign w_ld2    = !r_s2_valid || w_ld3;
    assign w_ld1    = !r_s1_valid || w_ld2;
    assign in_ready = w_ld1 && !rst;

    // ------------------------------------------------------------------------
    // S1: sign / magnitude. The most negative input negates to 2^(IN_W-1),
    // which still fits the unsigned IN_W-bit magnitude.
    // ------------------------------------------------------------------------
    logic            w_neg;
    logic [IN_W-1:0] w_mag;
    logic            r_s1_neg;
    logic [IN_W-1:0] r_s1_mag;

    assign w_neg = (SIGNED != 0) && in_data[IN_W-1];
    assign w_mag = w_neg ? (-in_data) : in_data;

    // ------------------------------------------------------------------------
    // S2: leading-one detect.
    // ------------------------------------------------------------------------
    logic [c_pw-1:0] w_lz;
    logic            w_lz_zero;
    logic            r_s2_neg;
    logic [IN_W-1:0] r_s2_mag;
    logic [c_pw-1:0] r_s2_lz;
    logic            r_s2_zero;

    lzc #(
        .WIDTH (IN_W),
        .CNT_W (c_pw)
    ) u_lzc (
        .i_vec   (r_s1_mag),
        .o_count (w_lz),
        .o_zero  (w_lz_zero)
    );

    // ------------------------------------------------------------------------
    // S3: normalise, round to nearest even, pack.
    // After the shift the hidden bit would sit at c_nw-1; it is dropped.
    // ------------------------------------------------------------------------
    logic [c_nw-2:0]    w_norm;
    logic [MAN-1:0]     w_man_trunc;
    logic               w_guard, w_sticky, w_round, w_carry, w_inexact;
    logic [MAN:0]       w_man_sum;
    logic [EXP-1:0]     w_exp;
    logic [EXP+MAN:0]   w_packed;

    assign w_norm      = (c_nw-1)'({r_s2_mag, {(MAN+2){1'b0}}} << r_s2_lz);
    assign w_man_trunc = w_norm[c_nw-2 -: MAN];
    assign w_guard     = w_norm[IN_W];
    assign w_sticky    = |w_norm[IN_W-1:0];
    assign w_round     = w_guard && (w_sticky || w_man_trunc[0]);
    assign w_man_sum   = {1'b0, w_man_trunc} + {{MAN{1'b0}}, w_round};
    // A carry out leaves the mantissa all zeros and bumps the exponent.
    assign w_carry     = w_man_sum[MAN];
    assign w_exp       = EXP'(c_exp_base) - EXP'(r_s2_lz) + EXP'(w_carry);
    assign w_inexact   = w_guard || w_sticky;
    assign w_packed    = r_s2_zero ? '0 : {r_s2_neg, w_exp, w_man_sum[MAN-1:0]};

    // ------------------------------------------------------------------------
    // Stage registers. Data is only captured alongside a valid bit so idle
    // outputs keep their last value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_neg    <= 1'b0;
            r_s1_mag    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_neg    <= 1'b0;
            r_s2_mag    <= '0;
            r_s2_lz     <= '0;
            r_s2_zero   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_zero    <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            if (w_ld1) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_neg <= w_neg;
                    r_s1_mag <= w_mag;
                end
            end
            if (w_ld2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_neg  <= r_s1_neg;
                    r_s2_mag  <= r_s1_mag;
                    r_s2_lz   <= w_lz;
                    r_s2_zero <= w_lz_zero;
                end
            end
            if (w_ld3) begin
                out_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    out_data    <= w_packed;
                    out_zero    <= r_s2_zero;
                    out_inexact <= r_s2_zero ? 1'b0 : w_inexact;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fxd2float_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fxd2float_pipe
//  Purpose  : Self-checking bench. Four converter configurations run in
//             lockstep (unsigned, signed, 32-bit wide, Q11.8) and are checked
//             against an arithmetic reference model, directed constants and
//             an occupancy model of the handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fxd2float_pipe;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic        inexact;
        int          cyc;
        bit          lat;
        bit          has_k;
        logic [31:0] kdata;
        logic        kzero;
        logic        kinx;
    } entry_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] din [4];
    logic        ir  [4];
    logic        ov  [4];
    logic        oz  [4];
    logic        oi  [4];
    logic [31:0] od  [4];

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cycle   = 0;
    int     occ     = 0;
    int     stall_left = 0;
    bit     acc, rand_rdy, lat_mode, dir_on, prev_rst, saw_full;
    int     dir_row;
    bit     prev_stall [4];
    logic [31:0] prev_od [4];
    entry_t sb [4][$];

    logic [31:0] dir_in  [4][4];
    logic [31:0] dir_exp [4][4];
    logic        dir_z   [4][4];
    logic        dir_x   [4][4];

    initial forever #5 clk = ~clk;

    fxd2float_pipe #(.IN_W(19), .FRAC_W(0), .SIGNED(0), .MAN(23), .EXP(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(din[0][18:0]),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_zero(oz[0]), .out_inexact(oi[0]));
    fxd2float_pipe #(.IN_W(19), .FRAC_W(0), .SIGNED(1), .MAN(23), .EXP(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(din[1][18:0]),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_zero(oz[1]), .out_inexact(oi[1]));
    fxd2float_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(0), .MAN(23), .EXP(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(din[2]),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_zero(oz[2]), .out_inexact(oi[2]));
    fxd2float_pipe #(.IN_W(19), .FRAC_W(8), .SIGNED(0), .MAN(23), .EXP(8)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_data(din[3][18:0]),
        .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .out_zero(oz[3]), .out_inexact(oi[3]));

    function automatic int cfg_inw(input int k);
        return (k == 2) ? 32 : 19;
    endfunction
    function automatic int cfg_frac(input int k);
        return (k == 3) ? 8 : 0;
    endfunction
    function automatic bit cfg_sgn(input int k);
        return (k == 1);
    endfunction

    // Reference: value = signed integer * 2^-frac, rounded to 24 significant
    // bits with ties to even, computed with plain integer arithmetic.
    function automatic entry_t model(input int k, input logic [31:0] raw);
        entry_t          e;
        longint unsigned v, mag, sc, q, rem, half;
        int              w, p, ex;
        bit              neg;
        w   = cfg_inw(k);
        v   = {32'd0, raw} & ((64'd1 << w) - 64'd1);
        neg = cfg_sgn(k) && (((v >> (w - 1)) & 64'd1) == 64'd1);
        mag = neg ? ((64'd1 << w) - v) : v;
        e.cyc = 0; e.lat = 0; e.has_k = 0; e.kdata = '0; e.kzero = 0; e.kinx = 0;
        if (mag == 0) begin
            e.data = '0; e.zero = 1'b1; e.inexact = 1'b0;
        end else begin
            p = 0;
            for (int i = 0; i < 40; i++) if (((mag >> i) & 64'd1) == 64'd1) p = i;
            sc   = mag << 23;
            q    = sc >> p;
            rem  = sc - (q << p);
            half = (p > 0) ? (64'd1 << (p - 1)) : 64'd0;
            if (p > 0 && (rem > half || (rem == half && q[0]))) q = q + 64'd1;
            ex = 127 + p - cfg_frac(k);
            if (q == (64'd1 << 24)) begin
                q  = 64'd1 << 23;
                ex = ex + 1;
            end
            e.data    = {neg, ex[7:0], q[22:0]};
            e.zero    = 1'b0;
            e.inexact = (rem != 0);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cycle, got, exp);
        end
    endtask

    // Negedge observation: handshake model, scoreboard, hold and reset checks.
    task automatic sample();
        entry_t e;
        acc = 1'b0;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rst_in_ready[%0d]", k), 32'(ir[k]), 32'd0);
                sb[k].delete();
                prev_stall[k] = 1'b0;
            end
            occ      = 0;
            prev_rst = 1'b1;
        end else begin
            if (!ir[0]) saw_full = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (prev_rst) begin
                    check($sformatf("post_rst_valid[%0d]", k), 32'(ov[k]), 32'd0);
                    check($sformatf("post_rst_data[%0d]", k), od[k], 32'd0);
                    check($sformatf("post_rst_zero[%0d]", k), 32'(oz[k]), 32'd0);
                    check($sformatf("post_rst_inexact[%0d]", k), 32'(oi[k]), 32'd0);
                end
                check($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'((occ != 3) || out_ready));
                if (prev_stall[k]) begin
                    check($sformatf("hold_valid[%0d]", k), 32'(ov[k]), 32'd1);
                    check($sformatf("hold_data[%0d]", k), od[k], prev_od[k]);
                end
                if (ov[k] && out_ready) begin
                    if (sb[k].size() == 0) begin
                        check($sformatf("spurious_out[%0d]", k), 32'(ov[k]), 32'd0);
                    end else begin
                        e = sb[k].pop_front();
                        check($sformatf("data[%0d]", k), od[k], e.data);
                        check($sformatf("zero[%0d]", k), 32'(oz[k]), 32'(e.zero));
                        check($sformatf("inexact[%0d]", k), 32'(oi[k]), 32'(e.inexact));
                        if (e.lat) check($sformatf("latency[%0d]", k), 32'(cycle - e.cyc), 32'd3);
                        if (e.has_k) begin
                            check($sformatf("dir_data[%0d]", k), od[k], e.kdata);
                            check($sformatf("dir_zero[%0d]", k), 32'(oz[k]), 32'(e.kzero));
                            check($sformatf("dir_inexact[%0d]", k), 32'(oi[k]), 32'(e.kinx));
                        end
                    end
                end
                prev_stall[k] = ov[k] && !out_ready;
                prev_od[k]    = od[k];
            end
            if (ov[0] && out_ready && occ > 0) occ--;
            if (in_valid && ir[0]) begin
                acc = 1'b1;
                occ++;
                for (int k = 0; k < 4; k++) begin
                    e       = model(k, din[k]);
                    e.cyc   = cycle;
                    e.lat   = lat_mode;
                    e.has_k = dir_on;
                    if (dir_on) begin
                        e.kdata = dir_exp[dir_row][k];
                        e.kzero = dir_z[dir_row][k];
                        e.kinx  = dir_x[dir_row][k];
                    end
                    sb[k].push_back(e);
                end
            end
            prev_rst = 1'b0;
        end
        cycle++;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    // Present one sample to all four converters and wait until it is taken.
    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        int n;
        din[0] = a; din[1] = b; din[2] = c; din[3] = d;
        in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc && n < 200);
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0:       r = 32'd0;
            1:       r = 32'h0004_0000;
            2:       r = 32'hFFFF_FFFF;
            3:       r = 32'h0100_0000 | ($urandom & 32'h3);
            default: r = $urandom >> $urandom_range(0, 31);
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] r;
        int          n;
        dir_in[0]  = '{32'd1024,      32'h0007_FC00, 32'h0100_0001, 32'h0000_0180};
        dir_in[1]  = '{32'd65536,     32'h0004_0000, 32'h0100_0003, 32'h0000_0001};
        dir_in[2]  = '{32'd123456,    32'h0000_0000, 32'h01FF_FFFF, 32'h0000_0100};
        dir_in[3]  = '{32'd0,         32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        dir_exp[0] = '{32'h4480_0000, 32'hC480_0000, 32'h4B80_0000, 32'h3FC0_0000};
        dir_exp[1] = '{32'h4780_0000, 32'hC880_0000, 32'h4B80_0002, 32'h3B80_0000};
        dir_exp[2] = '{32'h47F1_2000, 32'h0000_0000, 32'h4C00_0000, 32'h3F80_0000};
        dir_exp[3] = '{32'h0000_0000, 32'h3F80_0000, 32'h4F80_0000, 32'h0000_0000};
        dir_z[0]   = '{1'b0, 1'b0, 1'b0, 1'b0};
        dir_z[1]   = '{1'b0, 1'b0, 1'b0, 1'b0};
        dir_z[2]   = '{1'b0, 1'b1, 1'b0, 1'b0};
        dir_z[3]   = '{1'b1, 1'b0, 1'b0, 1'b1};
        dir_x[0]   = '{1'b0, 1'b0, 1'b1, 1'b0};
        dir_x[1]   = '{1'b0, 1'b0, 1'b1, 1'b0};
        dir_x[2]   = '{1'b0, 1'b0, 1'b1, 1'b0};
        dir_x[3]   = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            din[k] = '0; prev_stall[k] = 1'b0; prev_od[k] = '0;
        end
        rand_rdy = 0; lat_mode = 0; dir_on = 0; dir_row = 0; prev_rst = 0; saw_full = 0;

        // Reset
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Directed conversions, one at a time, with latency checks
        lat_mode = 1'b1;
        for (int r_i = 0; r_i < 4; r_i++) begin
            dir_row = r_i;
            dir_on  = 1'b1;
            push(dir_in[r_i][0], dir_in[r_i][1], dir_in[r_i][2], dir_in[r_i][3]);
            dir_on   = 1'b0;
            in_valid = 1'b0;
            repeat (4) step();
        end
        lat_mode = 1'b0;

        // Back-pressure: 10 back-to-back samples with a 5-cycle stall
        saw_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) stall_left = 5;
            r = gen();
            push(r, r, r, r);
        end
        in_valid = 1'b0;
        repeat (12) step();
        check("bp_in_ready_low", 32'(saw_full), 32'd1);

        // Reset with three samples in flight, then a fresh conversion
        for (int i = 0; i < 3; i++) begin
            r = gen();
            push(r, r, r, r);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        lat_mode = 1'b1;
        r = gen();
        push(r, r, r, r);
        in_valid = 1'b0;
        repeat (5) step();
        lat_mode = 1'b0;

        // Randomised traffic with random output stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                step();
            end
            r = gen();
            push(r, r, r, r);
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;

        // Drain
        n = 0;
        while (occ != 0 && n < 50) begin
            step();
            n++;
        end
        repeat (4) step();
        check("drain_occupancy", 32'(occ), 32'd0);
        for (int k = 0; k < 4; k++)
            check($sformatf("scoreboard_empty[%0d]", k), 32'(sb[k].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fxd2float_pipe.md
# fxd2float_pipe

Pipelined, parametrised fixed-point to IEEE-754-style floating-point converter, successor to the combinational `fxd2flot`. It adds signed and fractional (Qm.n) input formats, round-to-nearest-even with an inexact flag, and a valid/ready handshake with full back-pressure. It sits between fixed-point datapaths and float consumers, one sample per clock at full throughput.

## Interface
- `IN_W`, 19: input width in bits.
- `FRAC_W`, 0: fractional bits of the input; value = `in_data`·2^-FRAC_W.
- `SIGNED`, 0: 1 = two's-complement input, 0 = unsigned.
- `MAN`, 23: mantissa width, hidden bit excluded.
- `EXP`, 8: exponent width; bias = 2^(EXP-1)-1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: converter accepts a sample this cycle.
- `in_data` in IN_W: fixed-point sample.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 1+EXP+MAN: {sign, exponent, mantissa}.
- `out_zero` out 1: input was exactly zero.
- `out_inexact` out 1: rounding discarded nonzero bits.

## Operation
- S1, sign/magnitude: sign = SIGNED & in_data[IN_W-1]; mag = sign ? -in_data : in_data, held in IN_W unsigned bits. The most-negative input is exact; its magnitude is 2^(IN_W-1).
- S2, leading-one detect: p = index of the most significant 1 in mag, or zero flag if mag==0.
- S3, normalise, round, pack:
  - Shift mag left so bit p becomes the hidden bit. Take MAN bits below it.
  - If p > MAN: guard = next bit below, sticky = OR of the rest. Round up iff guard & (sticky | lsb).
  - inexact = guard | sticky.
  - Mantissa carry-out clears the mantissa and adds 1 to the exponent.
  - exponent = bias + p − FRAC_W.
- Zero input gives out_data = all zeros (+0.0), out_zero=1, out_inexact=0.
- No denormals, infinities or NaN are produced. Elaboration check (`$error`) that IN_W−FRAC_W ≤ bias and FRAC_W ≤ bias−1, so every input is a normal number.
- Each stage register has its own valid bit. A stage loads when its successor is empty or advancing. in_ready = !s1_valid | s1_advance.

## Timing
- Latency is 3 cycles from an accepted input (in_valid & in_ready) to out_valid.
- Throughput is 1 per clock while out_ready=1.
- out_data, out_zero and out_inexact are registered and hold stable while out_valid & !out_ready.
- Back-pressure: with out_ready=0, bubbles collapse first. in_ready falls only when all three stages hold valid data. No sample is dropped or duplicated.
- A simultaneous accept at the input and the output in the same cycle is legal when full; occupancy is unchanged.
- While rst=1 and on the first cycle after:
  - out_valid=0, out_data=0, out_zero=0, out_inexact=0.
  - in_ready=0 during reset and 1 after.
  - All stage valids are cleared.
- Reset mid-operation discards in-flight samples. No output is produced for them.

## Structure
- Package `fxd2float_pkg` holds:
  - a `float_fields` function that splits {sign, exp, man};
  - a `BIAS(EXP)` constant function;
  - a `clog2`-based width for the position of p.
- Sub-module `lzc` (width-parametrised leading-zero counter, combinational, with a zero flag) is instantiated in S2.
- Everything else stays in `fxd2float_pipe`.

## Test plan
- Defaults, inputs 1024, 65536, 123456, then 0 → 0x44800000, 0x47800000, 0x47F12000, then 0x00000000 with out_zero=1. Each appears 3 cycles after acceptance.
- SIGNED=1, inputs −1024 and −262144 (most negative) → 0xC4800000 and 0xC8800000.
- IN_W=32, inputs 0x01000001 and 0x01000003 → 0x4B800000 and 0x4B800002, both with out_inexact=1 (ties to even). Input 0x01FFFFFF → 0x4C000000 (mantissa carry into the exponent).
- FRAC_W=8, input 0x180 → 0x3FC00000 (1.5). Input 0x001 → 0x3B800000 (2^-8).
- Back-pressure: stream 10 back-to-back samples and hold out_ready=0 for 5 cycles mid-stream. Expect in_ready=0 after 3 samples are buffered, out_data stable while stalled, and all 10 results delivered in order with none lost.
- Assert rst for 1 cycle with 3 samples in flight → out_valid=0 the next cycle, no stale results afterwards, and a fresh sample converts with 3-cycle latency.
